uart_tx: RTL and testbench

- Serial UART transmitter. Pairs with the existing 16x-oversampled receiver on the same link.
- Takes a parallel byte on a one-cycle start strobe and shifts it out LSB first: start bit, DBIT data bits, optional parity, stop bit(s).
- Bit timing comes from the same shared s_tick enable (16 ticks per bit) that drives the receiver.
- Sits beside the receiver under the UART top, fed by a host-side FIFO or controller.

---
 rtl/uart_pkg.sv | 18 +
 rtl/uart_tx.sv | 95 +++++++++
 tb/tb_uart_tx.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: UART state encoding, oversample rate and frame-length helpers
// Shared by the transmitter and the receiver.
package uart_pkg;
  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;
  localparam int OVERSAMPLE = 16;
  localparam int SB_1 = 16;
  localparam int SB_1P5 = 24;
  localparam int SB_2 = 32;
  function automatic int frame_ticks(input int dbit, input int sb_tick, input bit parity);
    return OVERSAMPLE * (1 + dbit + int'(parity)) + sb_tick;
  endfunction
endpackage

// File: rtl/uart_tx.sv
// uart_tx: 16x-oversampled UART transmitter, LSB first, DBIT data bits, SB_TICK stop ticks.
// Define UART_TX_PARITY_EN to insert a parity bit (even, or odd when PARITY_ODD=1).
module uart_tx
  import uart_pkg::*;
#(
  parameter int DBIT = 8,
  parameter int SB_TICK = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       s_tick,
  input  logic       tx_start,
  input  logic [7:0] din,
  output logic       tx,
  output logic       tx_busy,
  output logic       tx_done_tick
);
  localparam logic [4:0] LAST_TICK = 5'(OVERSAMPLE - 1);
  localparam logic [4:0] STOP_LAST = 5'(SB_TICK - 1);
  localparam logic [2:0] LAST_BIT = 3'(DBIT - 1);
  state_t state;
  logic [4:0] s;
  logic [2:0] n;
  logic [DBIT-1:0] b;
  logic unused_cfg;
  assign unused_cfg = ^{din, 1'(PARITY_ODD)};
  assign tx_busy = state != IDLE;
  assign tx_done_tick = state == STOP && s_tick && s == STOP_LAST;
`ifdef UART_TX_PARITY_EN
  logic p;
  // parity is fixed from the byte captured at start, not the shifting register
  always_ff @(posedge clk)
    if (!reset) p <= 1'b0;
    else if (state == IDLE && tx_start) p <= ^din[DBIT-1:0] ^ 1'(PARITY_ODD);
`endif
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      s <= '0;
      n <= '0;
      b <= '0;
      tx <= 1'b1;
    end else begin
      case (state)
        IDLE: if (tx_start) begin
          b <= din[DBIT-1:0];
          s <= '0;
          state <= START;
          tx <= 1'b0;
        end
        START: if (s_tick) begin
          if (s == LAST_TICK) begin
            s <= '0;
            n <= '0;
            state <= DATA;
            tx <= b[0];
          end else s <= s + 5'd1;
        end
        DATA: if (s_tick) begin
          if (s == LAST_TICK) begin
            s <= '0;
            b <= b >> 1;
            if (n == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx <= p;
`else
              state <= STOP;
              tx <= 1'b1;
`endif
            end else begin
              n <= n + 3'd1;
              tx <= b[1];
            end
          end else s <= s + 5'd1;
        end
`ifdef UART_TX_PARITY_EN
        PARITY: if (s_tick) begin
          if (s == LAST_TICK) begin
            s <= '0;
            state <= STOP;
            tx <= 1'b1;
          end else s <= s + 5'd1;
        end
`endif
        STOP: if (s_tick) begin
          if (s == STOP_LAST) state <= IDLE;
          else s <= s + 5'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: three transmitters (8N1, 8N2, odd-parity variant) checked every cycle
// against a frame-level model; also decodes each frame mid-bit like a receiver.
module tb_uart_tx;
`ifdef UART_TX_PARITY_EN
  localparam int PB = 1;
`else
  localparam int PB = 0;
`endif
  logic clk, reset, s_tick;
  logic [2:0] tx_start, tx, busy, done;
  logic [7:0] din;
  int total = 0, bad = 0, cyc = 0;
  bit [2:0] act = '0;
  int t[3], dones[3], mdone[3], last_len[3];
  logic [7:0] byt[3], rx[3], last_rx[3];
  logic rxp[3], last_par[3];
  logic [2:0] done_seen;
  int sb[3] = '{16, 32, 16};
  bit odd[3] = '{1'b0, 1'b0, 1'b1};
  typedef struct {
    logic [7:0] d;
    int div;
    int len0;
    int len1;
    logic par;
  } vec_t;
  vec_t v[5];
  logic [7:0] q[4];

  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(0)) u0 (.clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start[0]), .din(din), .tx(tx[0]), .tx_busy(busy[0]), .tx_done_tick(done[0]));
  uart_tx #(.DBIT(8), .SB_TICK(32), .PARITY_ODD(0)) u1 (.clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start[1]), .din(din), .tx(tx[1]), .tx_busy(busy[1]), .tx_done_tick(done[1]));
  uart_tx #(.DBIT(8), .SB_TICK(16), .PARITY_ODD(1)) u2 (.clk(clk), .reset(reset), .s_tick(s_tick),
    .tx_start(tx_start[2]), .din(din), .tx(tx[2]), .tx_busy(busy[2]), .tx_done_tick(done[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int flen(input int i);
    return 16 * (1 + 8 + PB) + sb[i];
  endfunction

  // frame bits: start 0, data LSB first, optional parity, then stop (1)
  function automatic logic exp_bit(input int i, input int tt);
    int idx = tt / 16;
    if (idx == 0) return 1'b0;
    if (idx <= 8) return byt[i][idx-1];
    if (PB == 1 && idx == 9) return (($countones(byt[i]) & 1) != 0) ^ odd[i];
    return 1'b1;
  endfunction

  function automatic bit tick_at(input int div);
    return (cyc % div) == 0;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s dut%0d got=%0h want=%0h at %0t", nm, i, got, want, $time);
    end
  endtask

  task automatic step(input bit tk, input logic [2:0] st, input logic rst_n);
    int idx;
    s_tick = tk;
    tx_start = st;
    reset = rst_n;
    #1;
    done_seen = done;
    for (int i = 0; i < 3; i++) begin
      chk("tx", i, tx[i], act[i] ? exp_bit(i, t[i]) : 1'b1);
      chk("busy", i, busy[i], act[i]);
      chk("done", i, done[i], act[i] && tk && t[i] == flen(i) - 1);
      if (act[i] && tk && t[i] % 16 == 8) begin
        idx = t[i] / 16;
        if (idx >= 1 && idx <= 8) rx[i][idx-1] = tx[i];
        if (idx == 9) rxp[i] = tx[i];
      end
      if (done[i] === 1'b1) begin
        dones[i]++;
        last_len[i] = t[i] + 1;
        last_rx[i] = rx[i];
        last_par[i] = rxp[i];
      end
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) act[i] = 1'b0;
      else if (act[i]) begin
        if (tk) begin
          t[i]++;
          if (t[i] == flen(i)) begin
            act[i] = 1'b0;
            mdone[i]++;
          end
        end
      end else if (st[i]) begin
        act[i] = 1'b1;
        t[i] = 0;
        byt[i] = din;
      end
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic run_idle(input int div);
    int k = 0;
    while ((busy !== 3'b000 || act != 3'b000) && k < 4000) begin
      step(tick_at(div), 3'b000, 1'b1);
      k++;
    end
    chk("idle_timeout", 0, k < 4000, 1);
  endtask

  task automatic run_to(input int i, input int target);
    int k = 0;
    while (act[i] && t[i] < target && k < 4000) begin
      step(1'b1, 3'b000, 1'b1);
      k++;
    end
    chk("run_to_timeout", i, t[i], target);
  endtask

  initial begin
    int d0[3];
    int k, j;
    logic go;
    v[0] = '{8'hA5, 1, 160, 176, 1'b0};
    v[1] = '{8'h80, 1, 160, 176, 1'b1};
    v[2] = '{8'h00, 4, 160, 176, 1'b0};
    v[3] = '{8'hFF, 3, 160, 176, 1'b0};
    v[4] = '{8'h01, 2, 160, 176, 1'b1};
    for (int i = 0; i < 3; i++) begin
      t[i] = 0; dones[i] = 0; mdone[i] = 0; last_len[i] = 0;
      rx[i] = '0; rxp[i] = 1'b0; last_rx[i] = '0; last_par[i] = 1'b0; byt[i] = '0;
    end
    reset = 1'b0; s_tick = 1'b0; tx_start = '0; din = '0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_tx", i, tx[i], 1'b1);
      chk("rst_busy", i, busy[i], 1'b0);
      chk("rst_done", i, done[i], 1'b0);
    end
    // table: same byte on all three transmitters at once
    foreach (v[n]) begin
      for (int i = 0; i < 3; i++) d0[i] = dones[i];
      din = v[n].d;
      step(tick_at(v[n].div), 3'b111, 1'b1);
      run_idle(v[n].div);
      for (int i = 0; i < 3; i++) begin
        chk("frames", i, dones[i] - d0[i], 1);
        chk("byte", i, last_rx[i], v[n].d);
        chk("len", i, last_len[i], (i == 1 ? v[n].len1 : v[n].len0) + 16 * PB);
`ifdef UART_TX_PARITY_EN
        chk("parity", i, last_par[i], v[n].par ^ (i == 2));
`endif
      end
    end
    // back-to-back loopback, next start the cycle after done
    q = '{8'h00, 8'hFF, 8'h55, 8'h3C};
    d0[0] = dones[0];
    din = q[0];
    step(tick_at(4), 3'b001, 1'b1);
    k = 1;
    j = 0;
    for (int c = 0; c < 4000 && j < 4; c++) begin
      go = done_seen[0] && k < 4;
      if (go) begin
        din = q[k];
        k++;
      end
      step(tick_at(4), {2'b00, go}, 1'b1);
      if (done_seen[0] === 1'b1) begin
        chk("loop_byte", 0, last_rx[0], q[j]);
        j++;
      end
    end
    chk("loop_frames", 0, dones[0] - d0[0], 4);
    run_idle(4);
    // busy rejection: mid-DATA start and start in the done cycle are dropped
    d0[0] = dones[0];
    din = 8'h11;
    step(1'b1, 3'b001, 1'b1);
    run_to(0, 16 * 4);
    din = 8'h22;
    step(1'b1, 3'b001, 1'b1);
    run_to(0, flen(0) - 1);
    din = 8'h33;
    step(1'b1, 3'b001, 1'b1);
    chk("rej_done_cycle", 0, done_seen[0], 1'b1);
    repeat (300) step(1'b1, 3'b000, 1'b1);
    chk("rej_frames", 0, dones[0] - d0[0], 1);
    chk("rej_byte", 0, last_rx[0], 8'h11);
    chk("rej_busy", 0, busy[0], 1'b0);
    // reset during data bit 3
    d0[0] = dones[0];
    din = 8'hC3;
    step(1'b1, 3'b001, 1'b1);
    run_to(0, 16 * 4 + 5);
    step(1'b1, 3'b000, 1'b0);
    chk("mid_rst_tx", 0, tx[0], 1'b1);
    chk("mid_rst_busy", 0, busy[0], 1'b0);
    repeat (3) step(1'b1, 3'b000, 1'b1);
    chk("mid_rst_nodone", 0, dones[0] - d0[0], 0);
    din = 8'h5A;
    step(1'b1, 3'b001, 1'b1);
    run_idle(1);
    chk("post_rst_frames", 0, dones[0] - d0[0], 1);
    chk("post_rst_byte", 0, last_rx[0], 8'h5A);
    // random ticks, starts (often while busy) and rare resets
    for (int c = 0; c < 8000; c++) begin
      din = 8'($urandom);
      step($urandom_range(0, 2) == 0,
           {$urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0, $urandom_range(0, 39) == 0},
           $urandom_range(0, 2999) != 0);
    end
    run_idle(1);
    for (int i = 0; i < 3; i++) chk("rand_frames", i, dones[i], mdone[i]);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
